// File: rtl/decod_stage.sv
// decod_stage: registered instruction decode stage with a two-entry skid buffer.
// Optional sticky illegal-opcode trap is enabled by defining DECOD_ILLEGAL_TRAP_EN.
module decod_stage #(
  parameter int OPCODE_W = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int NUM_OPS = 6,
  localparam int INSTR_W = OPCODE_W + ADDR_W + 2 * DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instrucao,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] op_code,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   x,
  output logic [DATA_W-1:0]   y,
  output logic                illegal,
  output logic                trap
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  logic [INSTR_W-1:0] main_w, skid_w;
  logic main_ill, skid_ill, in_ill, acc, dlv, trap_n;

  assign acc = in_valid && in_ready && !flush;
  assign dlv = out_valid && out_ready;
  assign in_ill = {1'b0, instrucao[INSTR_W-1 -: OPCODE_W]} >= (OPCODE_W + 1)'(NUM_OPS);
  assign out_valid = state != EMPTY;
  assign {op_code, addr, x, y} = main_w;
  assign illegal = main_ill;

`ifdef DECOD_ILLEGAL_TRAP_EN
  assign trap_n = !flush && (trap || (acc && in_ill));
`else
  assign trap_n = 1'b0;
`endif

  // occupancy transitions; flush empties the stage regardless of handshakes
  always_comb begin
    state_n = flush ? EMPTY :
              state == EMPTY ? (acc ? ONE : EMPTY) :
              state == ONE ? ((acc && !dlv) ? TWO : (!acc && dlv) ? EMPTY : ONE) :
              (dlv ? ONE : TWO);
  end

  // storage: main feeds the outputs, skid catches the beat accepted while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      trap     <= 1'b0;
      main_w   <= '0;
      main_ill <= 1'b0;
      skid_w   <= '0;
      skid_ill <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != TWO) && !trap_n;
      trap     <= trap_n;
      if (acc && (state == EMPTY || dlv)) {main_ill, main_w} <= {in_ill, instrucao};
      else if (state == TWO && dlv) {main_ill, main_w} <= {skid_ill, skid_w};
      if (acc && state == ONE && !dlv) {skid_ill, skid_w} <= {in_ill, instrucao};
    end
  end
endmodule

// File: tb/tb_decod_stage.sv
// tb_decod_stage: scoreboard bench for decod_stage (default parameters).
module tb_decod_stage;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [23:0] instrucao = '0;
  logic in_ready, out_valid, illegal, trap;
  logic [2:0] op_code;
  logic [4:0] addr;
  logic [7:0] x, y;
  int n_cmp = 0, n_bad = 0;
  logic [24:0] q[$];

  decod_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instrucao(instrucao), .out_valid(out_valid), .out_ready(out_ready), .op_code(op_code),
    .addr(addr), .x(x), .y(y), .illegal(illegal), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // monitor: pop and compare on delivery, push the model word on acceptance
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("extra_word", 1, 0);
        else begin
          logic [24:0] e;
          e = q.pop_front();
          check("op_code", 32'(op_code), 32'(e[23:21]));
          check("addr", 32'(addr), 32'(e[20:16]));
          check("x", 32'(x), 32'(e[15:8]));
          check("y", 32'(y), 32'(e[7:0]));
          check("illegal", 32'(illegal), 32'(e[24]));
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back({instrucao[23:21] >= 3'd6, instrucao});
    end
  end

  task automatic drive(input logic [23:0] w);
    int n = 0;
    logic ok;
    in_valid = 1;
    instrucao = w;
    do begin
      @(negedge clk);
      ok = in_ready && !flush;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) check("drive_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [2:0] hold_op;
    logic [7:0] hold_y;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_trap", 32'(trap), 0);
    check("rst_fields", {op_code, addr, x, y}, 0);
    check("rst_illegal", 32'(illegal), 0);
    @(posedge clk); #1; rst_n = 1;
    idle(1);

    // single beat, fields by position
    out_ready = 0;
    drive(24'hA53C7E);
    @(negedge clk);
    check("one_valid", 32'(out_valid), 1);
    check("one_op", 32'(op_code), 5);
    check("one_addr", 32'(addr), 5);
    check("one_x", 32'(x), 32'h3C);
    check("one_y", 32'(y), 32'h7E);
    check("one_ill", 32'(illegal), 0);
    out_ready = 1;
    idle(2);

    // full-rate stream
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      instrucao = 24'(i + 1);
      @(negedge clk);
      check("stream_rdy", 32'(in_ready), 1);
      if (i > 0) check("stream_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    idle(3);
    check("stream_drained", 32'(q.size()), 0);

    // backpressure: three offers, two accepted
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      instrucao = 24'h4A0000 + 24'(i);
      @(negedge clk);
      check("bp_rdy", 32'(in_ready), (i < 2) ? 1 : 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    hold_op = op_code;
    hold_y = y;
    idle(2);
    check("bp_hold_rdy", 32'(in_ready), 0);
    check("bp_held", 32'(q.size()), 2);
    check("bp_stable", {op_code, y}, {hold_op, hold_y});
    out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_rdy_back", 32'(in_ready), 1);
    idle(2);
    check("bp_drained", 32'(q.size()), 0);

    // illegal opcode and optional trap
    drive(24'hE00000);
    @(negedge clk);
    check("trap_op", 32'(op_code), 7);
    check("trap_ill", 32'(illegal), 1);
`ifdef DECOD_ILLEGAL_TRAP_EN
    check("trap_set", 32'(trap), 1);
    check("trap_rdy", 32'(in_ready), 0);
`else
    check("trap_off", 32'(trap), 0);
    check("trap_off_rdy", 32'(in_ready), 1);
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      instrucao = 24'h200001;
      @(negedge clk);
`ifdef DECOD_ILLEGAL_TRAP_EN
      check("trap_hold", 32'(in_ready), 0);
`else
      check("notrap_flow", 32'(in_ready), 1);
`endif
      @(posedge clk); #1;
    end
    in_valid = 0;
    idle(2);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("flush_trap", 32'(trap), 0);
    check("flush_rdy", 32'(in_ready), 1);
    idle(2);

    // flush while full, with a beat presented in the same cycle
    out_ready = 0;
    drive(24'h111111);
    drive(24'h222222);
    @(negedge clk);
    check("two_rdy", 32'(in_ready), 0);
    in_valid = 1;
    instrucao = 24'h123456;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    check("fl_valid", 32'(out_valid), 0);
    check("fl_rdy", 32'(in_ready), 1);
    out_ready = 1;
    idle(4);

    // asynchronous reset while holding one word
    out_ready = 0;
    drive(24'h5F0F0F);
    #2;
    rst_n = 0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_fields", {op_code, addr, x, y}, 0);
    check("arst_rdy", 32'(in_ready), 1);
    idle(2);
    rst_n = 1;
    out_ready = 1;
    idle(3);
    check("end_queue", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
